io_uart_port: RTL and testbench

- Peripheral-side responder for the execution unit's byte IO handshake.
- Serves the core's IN requests (io_in_rdy/io_in_vld) from an RX FIFO filled by a UART receiver.
- Accepts the core's OUT bytes (io_out_vld/io_out_rdy) into a TX FIFO drained by a UART transmitter.
- Sits between the core and the board UART pins; 8N1 framing, LSB first.

---
 rtl/io_uart_pkg.sv | 20 ++
 rtl/byte_fifo.sv | 52 +++++
 rtl/io_uart_port.sv | 221 ++++++++++++++++++++++
 tb/tb_io_uart_port.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_uart_pkg.sv
// Shared types for the UART IO port: FSM state encodings and framing constants.
package io_uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with a combinational head output (zero when empty).
// A push into a full FIFO only succeeds when a pop happens in the same cycle.
module byte_fifo
  import io_uart_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int WIDTH   = DATA_BITS
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (FIFO_AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage array: written on accepted pushes, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      count <= count + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/io_uart_port.sv
// Core-side byte IO responder bridging to an 8N1 UART (LSB first).
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | waiting for a synced 1->0 edge on rxd
//   RX_START | half-bit wait, then confirm start bit (else glitch)
//   RX_DATA  | sampling 8 data bits at bit centres
//   RX_STOP  | sampling stop bit; push byte or flag framing error
// TX FSM
//   state    | meaning
//   TX_IDLE  | txd high; pops the next byte as soon as one is queued
//   TX_START | driving start bit (0) for one bit time
//   TX_DATA  | shifting out 8 data bits, one bit time each
//   TX_STOP  | driving stop bit (1) for one bit time
module io_uart_port
  import io_uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_AW     = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       io_in_rdy,
  output logic       io_in_vld,
  output logic [7:0] io_in_data,
  input  logic       io_out_vld,
  input  logic [7:0] io_out_data,
  output logic       io_out_rdy,
  input  logic       uart_rxd,
  output logic       uart_txd,
  input  logic       err_clr,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int CW = $clog2(CLK_PER_BIT) + 1;
  localparam logic [CW-1:0] BIT_TICKS  = CW'(CLK_PER_BIT);
  localparam logic [CW-1:0] HALF_TICKS = CW'(CLK_PER_BIT / 2);
  localparam logic [2:0]    LAST_BIT   = 3'(DATA_BITS - 1);

  // FIFO interfaces
  logic                 rx_push, rx_pop, rx_empty, rx_full;
  logic [DATA_BITS-1:0] rx_dout;
  logic                 tx_push, tx_pop, tx_empty, tx_full;
  logic [DATA_BITS-1:0] tx_dout;
  logic                 out_en;

  // RX datapath
  logic                 rx_meta, rx_s, rx_prev;
  rx_state_t            rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [2:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_tick, rx_stop_ok, rx_ovr_set, rx_fe_set;

  // TX datapath
  tx_state_t            tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [2:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_tick, txd;

  assign io_in_vld  = !rx_empty;
  assign io_in_data = rx_dout;
  assign rx_pop     = io_in_rdy && !rx_empty;
  assign io_out_rdy = out_en && !tx_full;
  assign tx_push    = io_out_vld && io_out_rdy;
  assign uart_txd   = txd;

  assign rx_tick    = (rx_cnt <= CW'(1));
  assign rx_stop_ok = (rx_state == RX_STOP) && rx_tick && rx_s;
  assign rx_push    = rx_stop_ok;
  assign rx_ovr_set = rx_stop_ok && rx_full && !rx_pop;
  assign rx_fe_set  = (rx_state == RX_STOP) && rx_tick && !rx_s;

  assign tx_tick    = (tx_cnt <= CW'(1));
  assign tx_pop     = (tx_state == TX_IDLE) && !tx_empty;

  byte_fifo #(.FIFO_AW(FIFO_AW), .WIDTH(DATA_BITS)) u_rx_fifo (
    .clk(clk), .rstn(rstn), .push(rx_push), .din(rx_shift),
    .pop(rx_pop), .dout(rx_dout), .empty(rx_empty), .full(rx_full)
  );

  byte_fifo #(.FIFO_AW(FIFO_AW), .WIDTH(DATA_BITS)) u_tx_fifo (
    .clk(clk), .rstn(rstn), .push(tx_push), .din(io_out_data),
    .pop(tx_pop), .dout(tx_dout), .empty(tx_empty), .full(tx_full)
  );

  // Hold off io_out_rdy until the first edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) out_en <= 1'b0;
    else       out_en <= 1'b1;
  end

  // Two-flop synchronizer plus edge-detect history for rxd (idle-high).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Receiver: start detect, centre sampling, stop check.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_cnt   <= HALF_TICKS;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_tick) begin
            if (!rx_s) begin
              rx_bit   <= '0;
              rx_cnt   <= BIT_TICKS;
              rx_state <= RX_DATA;
            end else begin
              rx_state <= RX_IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt - CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            rx_cnt   <= BIT_TICKS;
            if (rx_bit == LAST_BIT) rx_state <= RX_STOP;
            else                    rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_tick) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt - CW'(1);
          end
        end
      endcase
    end
  end

  // Sticky error flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_overrun   <= rx_ovr_set | (rx_overrun & ~err_clr);
      rx_frame_err <= rx_fe_set | (rx_frame_err & ~err_clr);
    end
  end

  // Transmitter: registered txd, one bit time per START/DATA/STOP bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (!tx_empty) begin
            tx_shift <= tx_dout;
            txd      <= 1'b0;
            tx_cnt   <= BIT_TICKS;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            txd      <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
            tx_bit   <= '0;
            tx_cnt   <= BIT_TICKS;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt - CW'(1);
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            tx_cnt <= BIT_TICKS;
            if (tx_bit == LAST_BIT) begin
              txd      <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              txd      <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
            end
          end else begin
            tx_cnt <= tx_cnt - CW'(1);
          end
        end
        TX_STOP: begin
          if (tx_tick) tx_state <= TX_IDLE;
          else         tx_cnt   <= tx_cnt - CW'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_port.sv
// Scoreboard bench for io_uart_port at 4 clocks per bit.
module tb_io_uart_port;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       io_in_rdy = 1'b0;
  logic       io_in_vld;
  logic [7:0] io_in_data;
  logic       io_out_vld = 1'b0;
  logic [7:0] io_out_data = 8'h00;
  logic       io_out_rdy;
  logic       uart_rxd = 1'b1;
  logic       uart_txd;
  logic       err_clr = 1'b0;
  logic       rx_overrun;
  logic       rx_frame_err;

  io_uart_port #(.CLK_PER_BIT(CPB), .FIFO_AW(4)) dut (
    .clk(clk), .rstn(rstn),
    .io_in_rdy(io_in_rdy), .io_in_vld(io_in_vld), .io_in_data(io_in_data),
    .io_out_vld(io_out_vld), .io_out_data(io_out_data), .io_out_rdy(io_out_rdy),
    .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .err_clr(err_clr), .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int rd_mode = 0;          // 0: rdy low, 1: random rdy, 2: driven by main
  int rdy_low = 0;
  logic [7:0] rx_q [$];     // bytes expected out of the IN port, in order
  logic [7:0] tx_q [$];     // bytes expected on uart_txd, in order
  int tx_starts [$];
  logic tx_active = 1'b0;
  int tx_k = 0;
  logic tx_samp [40];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
  endtask

  // IN-port monitor: decides rdy, and at every handshake pops the scoreboard.
  initial forever begin
    @(negedge clk); #1;
    if (rd_mode == 1)      io_in_rdy = 1'($urandom_range(0, 1));
    else if (rd_mode == 0) io_in_rdy = 1'b0;
    if (rstn && io_in_rdy && io_in_vld) begin
      check("rx_expected", 32'(rx_q.size() != 0), 1);
      if (rx_q.size() != 0) check("rx_data", 32'(io_in_data), 32'(rx_q.pop_front()));
    end
  end

  // Serial TX monitor: captures 40 cycles per frame and checks shape and payload.
  initial forever begin
    logic       shape_ok;
    logic [7:0] dec;
    @(negedge clk);
    if (!rstn) begin
      tx_active = 1'b0;
      tx_k = 0;
    end else if (!tx_active) begin
      if (uart_txd === 1'b0) begin
        tx_active = 1'b1;
        tx_samp[0] = 1'b0;
        tx_k = 1;
        tx_starts.push_back(cyc);
      end
    end else begin
      tx_samp[tx_k] = uart_txd;
      tx_k++;
      if (tx_k == 40) begin
        shape_ok = (tx_samp[0] == 1'b0) && (tx_samp[36] == 1'b1);
        for (int b = 0; b < 10; b++)
          for (int j = 1; j < CPB; j++)
            if (tx_samp[b*CPB+j] !== tx_samp[b*CPB]) shape_ok = 1'b0;
        for (int i = 0; i < 8; i++) dec[i] = tx_samp[(i+1)*CPB + 2];
        check("tx_frame_shape", 32'(shape_ok), 1);
        check("tx_expected", 32'(tx_q.size() != 0), 1);
        if (tx_q.size() != 0) check("tx_data", 32'(dec), 32'(tx_q.pop_front()));
        tx_active = 1'b0;
        tx_k = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rstn && !io_out_rdy) rdy_low++;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = f[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = 1'b1;
    @(negedge clk);
  endtask

  task automatic out_byte(input logic [7:0] b);
    int t;
    logic ok;
    t = 0;
    io_out_data = b;
    io_out_vld = 1'b1;
    while (!io_out_rdy && t < 200) begin
      @(negedge clk);
      t++;
    end
    ok = io_out_rdy;
    if (ok) tx_q.push_back(b);
    @(negedge clk);
    io_out_vld = 1'b0;
    check("out_accept", 32'(ok), 1);
  endtask

  task automatic wait_tx_drain(input string name);
    int t;
    t = 0;
    while ((tx_q.size() != 0 || tx_active) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check(name, 32'(t < 2000), 1);
  endtask

  task automatic wait_rx_drain(input string name);
    int t;
    t = 0;
    while (rx_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check(name, 32'(t < 2000), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    int max_gap;
    int min_gap;
    int low_cnt;
    logic exp_ovr;
    logic [7:0] b;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_in_vld", 32'(io_in_vld), 0);
    check("rst_in_data", 32'(io_in_data), 0);
    check("rst_out_rdy", 32'(io_out_rdy), 0);
    check("rst_txd", 32'(uart_txd), 1);
    check("rst_overrun", 32'(rx_overrun), 0);
    check("rst_frame_err", 32'(rx_frame_err), 0);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_release_out_rdy", 32'(io_out_rdy), 1);

    // TX single byte
    rdy_low = 0;
    out_byte(8'hA5);
    wait_tx_drain("tx_single_done");
    check("tx_single_rdy_high", 32'(rdy_low), 0);

    // RX single byte with manual read
    rd_mode = 2;
    io_in_rdy = 1'b0;
    rx_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    t = 0;
    while (!io_in_vld && t < 8) begin
      @(negedge clk);
      t++;
    end
    check("rx_single_vld", 32'(io_in_vld), 1);
    check("rx_single_data", 32'(io_in_data), 32'h3C);
    io_in_rdy = 1'b1;
    @(negedge clk);
    io_in_rdy = 1'b0;
    check("rx_single_pop", 32'(io_in_vld), 0);
    check("rx_single_consumed", 32'(rx_q.size()), 0);

    // RX overrun: 17 frames with no reads
    rd_mode = 0;
    exp_ovr = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (rx_q.size() < 16) rx_q.push_back(8'(i));
      else exp_ovr = 1'b1;
      send_frame(8'(i), 1'b1);
    end
    repeat (4) @(negedge clk);
    check("rx_overrun_set", 32'(rx_overrun), 32'(exp_ovr));
    check("rx_overrun_vld", 32'(io_in_vld), 1);
    rd_mode = 1;
    wait_rx_drain("rx_overrun_drain");
    rd_mode = 0;
    repeat (3) @(negedge clk);
    check("rx_overrun_empty_after", 32'(io_in_vld), 0);
    check("rx_overrun_sticky", 32'(rx_overrun), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("rx_overrun_clr", 32'(rx_overrun), 0);

    // RX one-cycle glitch
    uart_rxd = 1'b0;
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_no_byte", 32'(io_in_vld), 0);
    check("glitch_no_frame_err", 32'(rx_frame_err), 0);
    check("glitch_no_overrun", 32'(rx_overrun), 0);

    // RX framing error
    send_frame(8'h55, 1'b0);
    repeat (6) @(negedge clk);
    check("frame_err_set", 32'(rx_frame_err), 1);
    check("frame_err_no_byte", 32'(io_in_vld), 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("frame_err_clr", 32'(rx_frame_err), 0);

    // RX random bytes with random reader
    rd_mode = 1;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      rx_q.push_back(b);
      send_frame(b, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_rx_drain("rx_rand_drain");
    rd_mode = 0;
    check("rx_rand_no_err", 32'({rx_overrun, rx_frame_err}), 0);

    // TX random bytes with random gaps
    for (int i = 0; i < 6; i++) begin
      out_byte(8'($urandom));
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    wait_tx_drain("tx_rand_drain");

    // TX backpressure: fill FIFO behind a busy transmitter, then one held push
    tx_starts.delete();
    out_byte(8'h11);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 16; i++) out_byte(8'($urandom));
    check("tx_full_rdy_low", 32'(io_out_rdy), 0);
    out_byte(8'hE7);
    wait_tx_drain("tx_b2b_drain");
    max_gap = 0;
    min_gap = 100000;
    for (int i = 1; i < tx_starts.size(); i++) begin
      if (tx_starts[i] - tx_starts[i-1] > max_gap) max_gap = tx_starts[i] - tx_starts[i-1];
      if (tx_starts[i] - tx_starts[i-1] < min_gap) min_gap = tx_starts[i] - tx_starts[i-1];
    end
    check("tx_b2b_count", 32'(tx_starts.size()), 18);
    check("tx_b2b_gap", 32'(min_gap >= 10*CPB && max_gap <= 10*CPB + 1), 1);

    // Reset during TX data bit 3 (0x96 has bit3 = 0, so txd is low there)
    out_byte(8'h96);
    t = 0;
    while (!(tx_active && tx_k >= 4*CPB + 1) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("rst_mid_reach_bit3", 32'(t < 200), 1);
    rstn = 1'b0;
    #1;
    check("rst_mid_txd_high", 32'(uart_txd), 1);
    check("rst_mid_out_rdy_low", 32'(io_out_rdy), 0);
    tx_q.delete();
    rx_q.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_mid_out_rdy", 32'(io_out_rdy), 1);
    check("rst_mid_in_vld", 32'(io_in_vld), 0);
    low_cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (!uart_txd) low_cnt++;
    end
    check("rst_mid_no_resume", 32'(low_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
